// File: rtl/read_write_stuff.sv
// -----------------------------------------------------------------------------
// read_write_stuff
//   Five-slot product record store. Each 11-bit record is
//   [10:8] product number, [7:4] item count, [3:0] price. Slot N normally holds
//   the record for product N. Records are stored exactly as written; the
//   block does no arithmetic on them.
//
//   Optional feature (macro STORE_CHECK_EN): a written record whose product
//   number does not match its slot index is dropped for that slot only. The
//   other slots still update, wr_err pulses, and wr_done still pulses.
//   Without the macro every slot is written unconditionally and wr_err is 0.
//
// Ports
//   clock           rising-edge clock for all state
//   reset           asynchronous active-high reset
//   rd_en           snapshot all slots onto rd_p0..rd_p4 (1-cycle latency)
//   wr_en           commit wr_p0..wr_p4 into the slots
//   wr_p0..wr_p4    new slot records
//   rd_p0..rd_p4    registered slot snapshot, held between reads
//   rd_valid        one-cycle pulse after a read edge
//   wr_done         one-cycle pulse after a write edge
//   wr_err          one-cycle pulse after a write with a rejected slot
// -----------------------------------------------------------------------------
module read_write_stuff #(
    parameter logic [3:0] DEFAULT_COUNT = 4'd0,
    parameter logic [3:0] DEFAULT_PRICE = 4'd5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [10:0] wr_p0,
    input  logic [10:0] wr_p1,
    input  logic [10:0] wr_p2,
    input  logic [10:0] wr_p3,
    input  logic [10:0] wr_p4,
    output logic [10:0] rd_p0,
    output logic [10:0] rd_p1,
    output logic [10:0] rd_p2,
    output logic [10:0] rd_p3,
    output logic [10:0] rd_p4,
    output logic        rd_valid,
    output logic        wr_done,
    output logic        wr_err
);

    localparam int NUM_SLOTS = 5;

    logic [10:0]          slot_r   [NUM_SLOTS];
    logic [10:0]          rd_r     [NUM_SLOTS];
    logic [10:0]          wr_vec_s [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] accept_s;
    logic                 rd_valid_r;
    logic                 wr_done_r;

    // Reset record for a slot: its own product number plus the default fields.
    function automatic logic [10:0] default_rec(input logic [2:0] idx);
        return {idx, DEFAULT_COUNT, DEFAULT_PRICE};
    endfunction

    // Product-number check: a record belongs in the slot matching its number.
    function automatic logic rec_matches(input logic [10:0] rec, input logic [2:0] idx);
        return (rec[10:8] == idx);
    endfunction

    // Gather the write ports into an array so the slot logic can loop.
    always_comb begin
        wr_vec_s[0] = wr_p0;
        wr_vec_s[1] = wr_p1;
        wr_vec_s[2] = wr_p2;
        wr_vec_s[3] = wr_p3;
        wr_vec_s[4] = wr_p4;
    end

    // Per-slot write acceptance.
    always_comb begin
        accept_s = {NUM_SLOTS{1'b1}};
        for (int i = 0; i < NUM_SLOTS; i++) begin
`ifdef STORE_CHECK_EN
            accept_s[i] = rec_matches(wr_vec_s[i], 3'(i));
`else
            accept_s[i] = 1'b1;
`endif
        end
    end

    // Slot storage: written on wr_en, rejected slots keep their contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_r[i] <= default_rec(3'(i));
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (accept_s[i]) begin
                    slot_r[i] <= wr_vec_s[i];
                end
            end
        end
    end

    // Read snapshot: samples pre-edge slot contents, so a same-edge write
    // is only seen by the following read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                rd_r[i] <= default_rec(3'(i));
            end
        end else if (rd_en) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                rd_r[i] <= slot_r[i];
            end
        end
    end

    // Completion pulses, one cycle after each enabled edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            wr_done_r  <= 1'b0;
        end else begin
            rd_valid_r <= rd_en;
            wr_done_r  <= wr_en;
        end
    end

`ifdef STORE_CHECK_EN
    logic wr_err_r;

    // Error pulse when any slot of an accepted write was rejected.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_err_r <= 1'b0;
        end else begin
            wr_err_r <= wr_en && (accept_s != {NUM_SLOTS{1'b1}});
        end
    end

    assign wr_err = wr_err_r;
`else
    assign wr_err = 1'b0;
`endif

    assign rd_p0    = rd_r[0];
    assign rd_p1    = rd_r[1];
    assign rd_p2    = rd_r[2];
    assign rd_p3    = rd_r[3];
    assign rd_p4    = rd_r[4];
    assign rd_valid = rd_valid_r;
    assign wr_done  = wr_done_r;

endmodule

// File: tb/tb_read_write_stuff.sv
// -----------------------------------------------------------------------------
// tb_read_write_stuff
//   Directed-vector bench for read_write_stuff with hand-computed expectations.
//   Inputs change and outputs are sampled 1 ns after each rising clock edge.
//   Expectations for the product-number check follow STORE_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_read_write_stuff;

    logic        clock;
    logic        reset;
    logic        rd_en;
    logic        wr_en;
    logic [10:0] wr_p0, wr_p1, wr_p2, wr_p3, wr_p4;
    logic [10:0] rd_p0, rd_p1, rd_p2, rd_p3, rd_p4;
    logic        rd_valid;
    logic        wr_done;
    logic        wr_err;

    int n_vec;
    int n_miss;

    read_write_stuff dut (
        .clock    (clock),
        .reset    (reset),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .wr_p0    (wr_p0),
        .wr_p1    (wr_p1),
        .wr_p2    (wr_p2),
        .wr_p3    (wr_p3),
        .wr_p4    (wr_p4),
        .rd_p0    (rd_p0),
        .rd_p1    (rd_p1),
        .rd_p2    (rd_p2),
        .rd_p3    (rd_p3),
        .rd_p4    (rd_p4),
        .rd_valid (rd_valid),
        .wr_done  (wr_done),
        .wr_err   (wr_err)
    );

    // 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_value(input string tag, input logic [10:0] observed,
                               input logic [10:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_miss++;
            $display("FAIL %s: got 11'h%03h, expected 11'h%03h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns past the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_wr(input logic [10:0] p0, input logic [10:0] p1,
                          input logic [10:0] p2, input logic [10:0] p3,
                          input logic [10:0] p4);
        wr_p0 = p0; wr_p1 = p1; wr_p2 = p2; wr_p3 = p3; wr_p4 = p4;
    endtask

    task automatic check_all_rd(input string tag, input logic [10:0] e0,
                                input logic [10:0] e1, input logic [10:0] e2,
                                input logic [10:0] e3, input logic [10:0] e4);
        check_value({tag, "_rd_p0"}, rd_p0, e0);
        check_value({tag, "_rd_p1"}, rd_p1, e1);
        check_value({tag, "_rd_p2"}, rd_p2, e2);
        check_value({tag, "_rd_p3"}, rd_p3, e3);
        check_value({tag, "_rd_p4"}, rd_p4, e4);
    endtask

    logic [10:0] exp_slot3;
    logic [10:0] exp_err;

    initial begin
        n_vec  = 0;
        n_miss = 0;
`ifdef STORE_CHECK_EN
        exp_slot3 = 11'h305;
        exp_err   = 11'd1;
`else
        exp_slot3 = 11'h0FF;
        exp_err   = 11'd0;
`endif

        // Reset active before any edge, enables asserted with junk data.
        reset = 1'b1;
        rd_en = 1'b1;
        wr_en = 1'b1;
        set_wr(11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF);
        #2;
        check_all_rd("rst_noclk", 11'h005, 11'h105, 11'h205, 11'h305, 11'h405);
        check_value("rst_noclk_rd_valid", rd_valid, 11'd0);
        check_value("rst_noclk_wr_done", wr_done, 11'd0);
        check_value("rst_noclk_wr_err", wr_err, 11'd0);

        // Edges during reset are ignored.
        step();
        step();
        check_all_rd("rst_edge", 11'h005, 11'h105, 11'h205, 11'h305, 11'h405);
        check_value("rst_edge_rd_valid", rd_valid, 11'd0);
        check_value("rst_edge_wr_done", wr_done, 11'd0);

        // Release reset with enables low.
        reset = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        set_wr(11'h000, 11'h000, 11'h000, 11'h000, 11'h000);
        step();
        check_value("idle_rd_valid", rd_valid, 11'd0);
        check_value("idle_wr_done", wr_done, 11'd0);

        // First read after reset returns defaults, rd_valid pulses once.
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_value("rd1_rd_p2", rd_p2, 11'h205);
        check_value("rd1_rd_valid", rd_valid, 11'd1);
        step();
        check_value("rd1_rd_valid_drop", rd_valid, 11'd0);
        check_value("rd1_rd_p2_hold", rd_p2, 11'h205);

        // Write product 0 record; read port must not change until next read.
        wr_en = 1'b1;
        set_wr(11'h0A3, 11'h105, 11'h205, 11'h305, 11'h405);
        step();
        wr_en = 1'b0;
        check_value("wr1_wr_done", wr_done, 11'd1);
        check_value("wr1_wr_err", wr_err, 11'd0);
        check_value("wr1_rd_p0_hold", rd_p0, 11'h005);
        step();
        check_value("wr1_wr_done_drop", wr_done, 11'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_all_rd("rd2", 11'h0A3, 11'h105, 11'h205, 11'h305, 11'h405);
        check_value("rd2_rd_valid", rd_valid, 11'd1);

        // Same-edge read and write: read sees old slot1, next read sees new.
        rd_en = 1'b1;
        wr_en = 1'b1;
        set_wr(11'h0A3, 11'h1F2, 11'h205, 11'h305, 11'h405);
        step();
        rd_en = 1'b0;
        wr_en = 1'b0;
        check_value("rw_rd_p1_old", rd_p1, 11'h105);
        check_value("rw_rd_valid", rd_valid, 11'd1);
        check_value("rw_wr_done", wr_done, 11'd1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_value("rw_rd_p1_new", rd_p1, 11'h1F2);

        // Mismatched product number in slot 3, max count/price in slot 2.
        wr_en = 1'b1;
        set_wr(11'h0A3, 11'h1F2, 11'h2FF, 11'h0FF, 11'h4C7);
        step();
        wr_en = 1'b0;
        check_value("chk_wr_done", wr_done, 11'd1);
        check_value("chk_wr_err", wr_err, exp_err);
        step();
        check_value("chk_wr_err_drop", wr_err, 11'd0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_all_rd("chk", 11'h0A3, 11'h1F2, 11'h2FF, exp_slot3, 11'h4C7);

        // Back-to-back writes and reads on slot 0; read lags write by one.
        rd_en = 1'b1;
        wr_en = 1'b1;
        set_wr(11'h011, 11'h1F2, 11'h2FF, 11'h305, 11'h4C7);
        step();
        check_value("b2b_a_rd_p0", rd_p0, 11'h0A3);
        wr_p0 = 11'h022;
        step();
        check_value("b2b_b_rd_p0", rd_p0, 11'h011);
        check_value("b2b_b_wr_done", wr_done, 11'd1);
        wr_p0 = 11'h033;
        step();
        check_value("b2b_c_rd_p0", rd_p0, 11'h022);
        check_value("b2b_c_rd_valid", rd_valid, 11'd1);
        step();
        check_value("b2b_d_rd_p0", rd_p0, 11'h033);

        // Reset mid-stream with both enables still asserted.
        reset = 1'b1;
        #1;
        check_all_rd("rst_mid", 11'h005, 11'h105, 11'h205, 11'h305, 11'h405);
        check_value("rst_mid_rd_valid", rd_valid, 11'd0);
        check_value("rst_mid_wr_done", wr_done, 11'd0);
        check_value("rst_mid_wr_err", wr_err, 11'd0);
        step();
        reset = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        step();
        // Storage itself was reset, not just the read port.
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_all_rd("post_rst", 11'h005, 11'h105, 11'h205, 11'h305, 11'h405);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/read_write_stuff.md
READ_WRITE_STUFF -- requirements
Module: read_write_stuff

Interface
REQ-001 The block SHALL have parameter DEFAULT_COUNT, default 4'd0, which is the count field loaded into every slot at reset.
REQ-002 The block SHALL have parameter DEFAULT_PRICE, default 4'd5, which is the price field loaded into every slot at reset.
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port rd_en, input, 1 bit, which requests a snapshot of all slots onto rd_p0..rd_p4.
REQ-006 The block SHALL have port wr_en, input, 1 bit, which commits wr_p0..wr_p4 into storage.
REQ-007 The block SHALL have ports wr_p0..wr_p4, input, 11 bits each, the new slot records.
REQ-008 The block SHALL have ports rd_p0..rd_p4, output, 11 bits each, registered slot records.
REQ-009 The block SHALL have port rd_valid, output, 1 bit, a one-cycle pulse when rd_p* has been refreshed.
REQ-010 The block SHALL have port wr_done, output, 1 bit, a one-cycle pulse when a write has been accepted.
REQ-011 The block SHALL have port wr_err, output, 1 bit, a one-cycle pulse when any slot was rejected; it exists only with STORE_CHECK_EN, otherwise it is tied to 0.

Function
REQ-012 The record format SHALL be [10:8] product number, [7:4] item count (0..15), [3:0] price (0..15).
REQ-013 Storage SHALL be five 11-bit registers, slot0..slot4, indexed by product number 0..4.
REQ-014 On a rising edge with wr_en=1, each slotN SHALL load wr_pN, subject to REQ-024.
REQ-015 wr_done SHALL be 1 in the cycle after an edge with wr_en=1, otherwise 0.
REQ-016 On a rising edge with rd_en=1, rd_pN SHALL load the pre-edge value of slotN (1-cycle latency).
REQ-017 rd_valid SHALL be 1 in the cycle after an edge with rd_en=1, otherwise 0.
REQ-018 rd_p* SHALL hold their value while rd_en=0; a write does not change them until the next read.
REQ-019 With rd_en=1 and wr_en=1 on the same edge, rd_p* SHALL return the old contents; the new data is visible on the following read.
REQ-020 The block SHALL do no arithmetic on the fields; count and price are stored verbatim, with no saturation or wrap.
REQ-021 Back-to-back writes and reads every cycle SHALL be supported with no stall and no handshake beyond the enables.

Reset
REQ-022 While reset=1, slotN and rd_pN SHALL equal {N[2:0], DEFAULT_COUNT, DEFAULT_PRICE}, and rd_valid, wr_done and wr_err SHALL be 0, independent of clock.
REQ-023 An edge coinciding with active reset SHALL be ignored; the first enable is sampled on the first rising edge after reset falls.

Configuration
REQ-024 With macro STORE_CHECK_EN defined, a written record whose wr_pN[10:8] != N SHALL leave slotN unchanged, while the other slots still update; wr_err SHALL pulse for one cycle and wr_done SHALL still pulse.
REQ-025 Without STORE_CHECK_EN, all five slots SHALL be written unconditionally and wr_err SHALL be constant 0.

Verification
REQ-026 Reset released, rd_en pulse -> rd_p2=11'b010_0000_0101 with defaults, rd_valid high for 1 cycle.
REQ-027 wr_en with wr_p0=11'h0A3 (prod0, count10, price3), then rd_en -> rd_p0=11'h0A3, other slots unchanged, wr_done pulses once.
REQ-028 rd_en and wr_en on the same edge with wr_p1=11'h1F2 -> rd_p1 shows default 11'h105; the next rd_en shows 11'h1F2.
REQ-029 Asserting reset mid-stream after writes -> all rd_p*/slots return to defaults immediately; rd_valid and wr_done are 0.
REQ-030 With STORE_CHECK_EN, wr_p3=11'h0FF (wrong number) -> slot3 unchanged, wr_err pulses, other slots written; without the macro -> slot3=11'h0FF and wr_err=0.
